// File: rtl/onc_16_dmem_pkg.sv
// Shared constants and types for the ONC-16 data-memory subsystem.
package onc_16_dmem_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [DATA_W-1:0] IO_BASE_DEF = 16'hFF00;

  // Offsets within the I/O page (low byte of the address).
  localparam logic [7:0] IO_GPIO      = 8'h00;
  localparam logic [7:0] IO_CYCLE     = 8'h01;
  localparam logic [7:0] IO_UART_DATA = 8'h02;
  localparam logic [7:0] IO_UART_STAT = 8'h03;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/onc_16_uart_tx.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, stop bit.
module onc_16_uart_tx
  import onc_16_dmem_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic       clock,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  uart_state_t   state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    data_q;
  logic          tx_n;

  // State, counters, latched byte and the registered line output.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state  <= UART_IDLE;
      baud   <= '0;
      idx    <= '0;
      data_q <= '0;
      tx     <= 1'b1;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      tx    <= tx_n;
      if (state == UART_IDLE && start) data_q <= data;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    idx_n   = idx;
    unique case (state)
      UART_IDLE: begin
        baud_n = '0;
        idx_n  = '0;
        if (start) state_n = UART_START;
      end
      UART_START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          idx_n   = '0;
          state_n = UART_DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      UART_DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (idx == 3'd7) state_n = UART_STOP;
          else             idx_n   = idx + 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      UART_STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          state_n = UART_IDLE;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = UART_IDLE;
    endcase
  end

  // Line level decoded from the next state so tx is registered and
  // switches on the same edge as the state; data_q is already valid
  // whenever the next state is DATA.
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      UART_START: tx_n = 1'b0;
      UART_DATA:  tx_n = data_q[idx_n];
      default:    tx_n = 1'b1;
    endcase
  end

  assign busy = (state != UART_IDLE);

endmodule

// File: rtl/onc_16_dmem.sv
// ONC-16 data memory: word RAM plus an I/O page with GPIO, cycle counter
// and serial transmitter. Read data is combinational.
module onc_16_dmem
  import onc_16_dmem_pkg::*;
#(
  parameter int unsigned        RAM_AW   = 8,
  parameter int unsigned        BAUD_DIV = 16,
  parameter logic [DATA_W-1:0]  IO_BASE  = IO_BASE_DEF
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_we,
  output logic [DATA_W-1:0] dmem_din,
  output logic [DATA_W-1:0] gpio_out,
  output logic              uart_tx
);

  logic [DATA_W-1:0] ram [0:(1 << RAM_AW) - 1];
  logic [DATA_W-1:0] cycle_cnt;
  logic              is_io;
  logic [7:0]        io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              uart_busy;
  logic              uart_start;

  assign is_io      = (dmem_addr >= IO_BASE);
  assign io_off     = dmem_addr[7:0];
  assign ram_idx    = dmem_addr[RAM_AW-1:0];
  assign uart_start = dmem_we && is_io && (io_off == IO_UART_DATA);

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (dmem_we && !is_io) ram[ram_idx] <= dmem_dout;
  end

  // GPIO output register.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst)                                      gpio_out <= '0;
    else if (dmem_we && is_io && io_off == IO_GPIO)  gpio_out <= dmem_dout;
  end

  // Free-running cycle counter; a write clears it in preference to counting.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst)                                      cycle_cnt <= '0;
    else if (dmem_we && is_io && io_off == IO_CYCLE) cycle_cnt <= '0;
    else                                             cycle_cnt <= cycle_cnt + 1'b1;
  end

  onc_16_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clock (clock),
    .n_rst (n_rst),
    .start (uart_start),
    .data  (dmem_dout[7:0]),
    .busy  (uart_busy),
    .tx    (uart_tx)
  );

  // Read mux, independent of dmem_we.
  always_comb begin
    dmem_din = '0;
    if (!is_io) begin
      dmem_din = ram[ram_idx];
    end else begin
      unique case (io_off)
        IO_GPIO:      dmem_din = gpio_out;
        IO_CYCLE:     dmem_din = cycle_cnt;
        IO_UART_STAT: dmem_din = {{(DATA_W-1){1'b0}}, uart_busy};
        default:      dmem_din = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_onc_16_dmem.sv
// Directed bench for onc_16_dmem (RAM_AW=8, BAUD_DIV=4).
module tb_onc_16_dmem;

  logic        clock = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] dmem_addr = '0;
  logic [15:0] dmem_dout = '0;
  logic        dmem_we   = 1'b0;
  logic [15:0] dmem_din;
  logic [15:0] gpio_out;
  logic        uart_tx;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  onc_16_dmem #(
    .RAM_AW   (8),
    .BAUD_DIV (4),
    .IO_BASE  (16'hFF00)
  ) dut (
    .clock     (clock),
    .n_rst     (n_rst),
    .dmem_addr (dmem_addr),
    .dmem_dout (dmem_dout),
    .dmem_we   (dmem_we),
    .dmem_din  (dmem_din),
    .gpio_out  (gpio_out),
    .uart_tx   (uart_tx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        chk_din;
    logic [15:0] exp_din;   // before the edge
    logic [15:0] exp_gpio;  // after the edge
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Send one byte and check the line bit by bit; frame[k] is the level of bit k.
  task automatic uart_frame(input logic [15:0] d, input logic [9:0] frame, input bit inject);
    @(negedge clock);
    dmem_we = 1'b1; dmem_addr = 16'hFF02; dmem_dout = d;
    @(posedge clock);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      dmem_we   = inject && (i == 8 || i == 39);
      dmem_addr = dmem_we ? 16'hFF02 : 16'hFF03;
      dmem_dout = 16'h00FF;
      #1;
      check($sformatf("tx_bit%0d", i), {15'b0, uart_tx}, {15'b0, frame[i/4]});
      if (!dmem_we) check($sformatf("busy%0d", i), dmem_din, 16'h0001);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      dmem_we = 1'b0; dmem_addr = 16'hFF03;
      #1;
      check("tx_idle", {15'b0, uart_tx}, 16'h0001);
      check("busy_idle", dmem_din, 16'h0000);
    end
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1'b1, 16'h0110, 16'h1234, 1'b1, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 16'h0000};
    vecs[4]  = '{1'b0, 16'hFF10, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b1, 16'hFF00, 16'h00A5, 1'b1, 16'h0000, 16'h00A5};
    vecs[6]  = '{1'b0, 16'hFF00, 16'h0000, 1'b1, 16'h00A5, 16'h00A5};
    vecs[7]  = '{1'b1, 16'hFF04, 16'h7777, 1'b1, 16'h0000, 16'h00A5};
    vecs[8]  = '{1'b1, 16'hFF03, 16'h0001, 1'b1, 16'h0000, 16'h00A5};
    vecs[9]  = '{1'b0, 16'hFF02, 16'h0000, 1'b1, 16'h0000, 16'h00A5};
    vecs[10] = '{1'b1, 16'hFEFF, 16'h5A5A, 1'b0, 16'h0000, 16'h00A5};
    vecs[11] = '{1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h5A5A, 16'h00A5};

    // Reset release and counter start value.
    repeat (3) @(negedge clock);
    n_rst = 1'b1;
    dmem_addr = 16'hFF01;
    #1 check("cycle_after_rst", dmem_din, 16'h0000);
    dmem_addr = 16'hFF03;
    #1 check("stat_after_rst", dmem_din, 16'h0000);
    dmem_addr = 16'hFF01;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("cycle_5", dmem_din, 16'h0005);

    // Counter clear.
    dmem_we = 1'b1; dmem_dout = 16'h1234;
    @(posedge clock);
    @(negedge clock);
    dmem_we = 1'b0;
    #1 check("cycle_clr0", dmem_din, 16'h0000);
    @(negedge clock);
    check("cycle_clr1", dmem_din, 16'h0001);

    // Table of single-cycle accesses.
    foreach (vecs[k]) begin
      @(negedge clock);
      dmem_we = vecs[k].we; dmem_addr = vecs[k].addr; dmem_dout = vecs[k].dout;
      #1;
      if (vecs[k].chk_din) check($sformatf("vec%0d_din", k), dmem_din, vecs[k].exp_din);
      @(posedge clock);
      #1 check($sformatf("vec%0d_gpio", k), gpio_out, vecs[k].exp_gpio);
    end
    @(negedge clock);
    dmem_we = 1'b0;

    // Asynchronous reset mid-run.
    #2 n_rst = 1'b0;
    #1 check("rst_gpio", gpio_out, 16'h0000);
    check("rst_tx", {15'b0, uart_tx}, 16'h0001);
    @(negedge clock);
    n_rst = 1'b1;
    dmem_addr = 16'hFF01;
    #1 check("rst_cycle", dmem_din, 16'h0000);

    // Frame of 0x55 with writes during busy and on the returning edge.
    uart_frame(16'h0155, 10'b1_0101_0101_0, 1'b1);

    // Reset during data bit 3 (cycles 16..19 after acceptance).
    @(negedge clock);
    dmem_we = 1'b1; dmem_addr = 16'hFF02; dmem_dout = 16'h0155;
    @(posedge clock);
    @(negedge clock);
    dmem_we = 1'b0; dmem_addr = 16'hFF03;
    repeat (17) @(negedge clock);
    #1 check("pre_abort_busy", dmem_din, 16'h0001);
    #1 n_rst = 1'b0;
    #1 check("abort_tx", {15'b0, uart_tx}, 16'h0001);
    check("abort_busy", dmem_din, 16'h0000);
    @(negedge clock);
    n_rst = 1'b1;
    uart_frame(16'h00C3, 10'b1_1100_0011_0, 1'b0);

    // Counter wrap.
    @(negedge clock);
    dmem_we = 1'b1; dmem_addr = 16'hFF01;
    @(posedge clock);
    @(negedge clock);
    dmem_we = 1'b0;
    repeat (65535) @(posedge clock);
    @(negedge clock);
    check("cycle_ffff", dmem_din, 16'hFFFF);
    @(negedge clock);
    check("cycle_wrap", dmem_din, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
